// File: rtl/io_pkg.sv
// Shared types and defaults for the IN/OUT handshake controller.
package io_pkg;

  localparam int IO_DATA_W           = 32;
  localparam int IO_DEBOUNCE_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_IN,
    WAIT_OUT,
    ACK_IN,
    ACK_OUT,
    RELEASE
  } io_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Insert-button conditioner: 2-flop sync, stability counter, rising-edge pulse.
// Latency: raw high -> press = 2 + DEBOUNCE_CYCLES + 1 cycles.
// No backpressure: press is a free-running one-cycle pulse.
module btn_debounce
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = IO_DEBOUNCE_DEFAULT
) (
  input  logic CLK,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= btn_raw;
      sync2 <= sync1;
      press <= 1'b0;
      // Any sample agreeing with the accepted level restarts the count.
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_MAX) begin
        level <= sync2;
        press <= sync2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/io_handshake.sv
// Holds the PC on IN/OUT until a debounced insert press, then pulses insert.
// Latency: press -> insert 1 cycle, insert -> IDLE 2 cycles; flags hold the PC meanwhile.
// Backpressure: the PC is stalled via input_flag/output_flag; presses outside WAIT are dropped.
module io_handshake
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = IO_DEBOUNCE_DEFAULT,
  parameter int DATA_W          = IO_DATA_W
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              is_in,
  input  logic              is_out,
  input  logic [DATA_W-1:0] out_src,
  input  logic [DATA_W-1:0] switches,
  input  logic              btn_insert,
  output logic              input_flag,
  output logic              output_flag,
  output logic              insert,
  output logic [DATA_W-1:0] in_data,
  output logic              in_we,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid
);

  io_state_t state;
  logic      press;
  logic      level;
  logic      go;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .CLK    (CLK),
    .reset  (reset),
    .btn_raw(btn_insert),
    .level  (level),
    .press  (press)
  );

  // press only fires together with the new high level; gating is belt and braces.
  assign go = press & level;

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      in_data   <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      in_we     <= 1'b0;
      insert    <= 1'b0;
    end else begin
      in_we  <= 1'b0;
      insert <= 1'b0;
      case (state)
        IDLE: begin
          if (is_in) begin
            state <= WAIT_IN;
          end else if (is_out) begin
            state     <= WAIT_OUT;
            out_data  <= out_src;
            out_valid <= 1'b1;
          end
        end
        WAIT_IN: begin
          if (go) begin
            state   <= ACK_IN;
            in_data <= switches;
            in_we   <= 1'b1;
            insert  <= 1'b1;
          end
        end
        WAIT_OUT: begin
          if (go) begin
            state  <= ACK_OUT;
            insert <= 1'b1;
          end
        end
        ACK_IN, ACK_OUT: state <= RELEASE;
        RELEASE:         state <= IDLE;
        default:         state <= IDLE;
      endcase
    end
  end

  // IDLE terms are combinational so the PC stalls in the instruction's first cycle.
  assign input_flag  = ((state == IDLE) && is_in) || (state == WAIT_IN) || (state == ACK_IN);
  assign output_flag = ((state == IDLE) && is_out && !is_in) ||
                       (state == WAIT_OUT) || (state == ACK_OUT);

endmodule

// File: tb/tb_io_handshake.sv
// Directed bench for io_handshake with DEBOUNCE_CYCLES = 16.
module tb_io_handshake;
  import io_pkg::*;

  logic        CLK = 1'b0;
  logic        reset;
  logic        is_in, is_out;
  logic [31:0] out_src, switches;
  logic        btn_insert;
  logic        input_flag, output_flag, insert, in_we, out_valid;
  logic [31:0] in_data, out_data;

  int tests = 0;
  int fails = 0;
  int ins_cnt = 0;
  int we_cnt = 0;

  io_handshake #(.DEBOUNCE_CYCLES(16), .DATA_W(32)) dut (
    .CLK        (CLK),
    .reset      (reset),
    .is_in      (is_in),
    .is_out     (is_out),
    .out_src    (out_src),
    .switches   (switches),
    .btn_insert (btn_insert),
    .input_flag (input_flag),
    .output_flag(output_flag),
    .insert     (insert),
    .in_data    (in_data),
    .in_we      (in_we),
    .out_data   (out_data),
    .out_valid  (out_valid)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (insert) ins_cnt++;
    if (in_we)  we_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Bounded wait for insert; n is the number of edges it took.
  task automatic wait_ins(input int maxc, output bit got, output int n);
    got = 1'b0;
    n   = 0;
    while (!got && n < maxc) begin
      tick();
      n++;
      if (insert) got = 1'b1;
    end
  endtask

  bit got;
  int n;
  int ins_save, we_save;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; is_in = 1'b0; is_out = 1'b0;
    out_src = '0; switches = '0; btn_insert = 1'b0;
    run(3);
    chk("rst_state",    32'(dut.state), 32'(IDLE));
    chk("rst_in_data",  in_data, 32'h0);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_outputs",  {28'h0, out_valid, in_we, insert, input_flag}, 32'h0);
    reset = 1'b0;
    run(2);

    // IN with a clean press held 20 cycles
    is_in = 1'b1; switches = 32'h0000_00A5;
    #1;
    chk("in_flag_first", {31'h0, input_flag}, 32'h1);
    chk("in_oflag_low",  {31'h0, output_flag}, 32'h0);
    tick();
    chk("in_wait_state", 32'(dut.state), 32'(WAIT_IN));
    btn_insert = 1'b1;
    wait_ins(40, got, n);
    chk("in_insert_seen", {31'h0, got}, 32'h1);
    chk("in_latency",     n, 32'd20);
    chk("in_we_with_ins", {31'h0, in_we}, 32'h1);
    chk("in_data_a5",     in_data, 32'h0000_00A5);
    is_in = 1'b0;
    tick();
    chk("in_release", 32'(dut.state), 32'(RELEASE));
    tick();
    chk("in_idle_2cyc", 32'(dut.state), 32'(IDLE));
    btn_insert = 1'b0;
    run(25);
    chk("in_ins_count", ins_cnt, 32'd1);
    chk("in_we_count",  we_cnt, 32'd1);

    // OUT
    is_out = 1'b1; out_src = 32'hDEAD_BEEF;
    #1;
    chk("out_flag_first", {31'h0, output_flag}, 32'h1);
    chk("out_iflag_low",  {31'h0, input_flag}, 32'h0);
    tick();
    chk("out_data_cap",  out_data, 32'hDEAD_BEEF);
    chk("out_valid_set", {31'h0, out_valid}, 32'h1);
    chk("out_wait",      32'(dut.state), 32'(WAIT_OUT));
    btn_insert = 1'b1;
    wait_ins(40, got, n);
    chk("out_insert_seen", {31'h0, got}, 32'h1);
    chk("out_latency",     n, 32'd20);
    chk("out_no_we",       {31'h0, in_we}, 32'h0);
    is_out = 1'b0;
    run(2);
    chk("out_idle", 32'(dut.state), 32'(IDLE));
    btn_insert = 1'b0;
    run(25);
    chk("out_ins_count", ins_cnt, 32'd2);
    chk("out_we_count",  we_cnt, 32'd1);
    chk("out_valid_hold", {31'h0, out_valid}, 32'h1);

    // Bouncing press
    is_in = 1'b1; switches = 32'h0000_005A;
    tick();
    for (int k = 0; k < 4; k++) begin
      btn_insert = ~k[0];
      run(3);
    end
    chk("bnc_no_early", ins_cnt, 32'd2);
    btn_insert = 1'b1;
    wait_ins(40, got, n);
    chk("bnc_insert_seen", {31'h0, got}, 32'h1);
    chk("bnc_latency",     n, 32'd20);
    chk("bnc_data",        in_data, 32'h0000_005A);
    is_in = 1'b0;
    run(2);
    chk("bnc_ins_count", ins_cnt, 32'd3);

    // Button held into the next IN
    is_in = 1'b1; switches = 32'h0000_0077;
    run(30);
    chk("hold_wait",    32'(dut.state), 32'(WAIT_IN));
    chk("hold_no_ins",  ins_cnt, 32'd3);
    btn_insert = 1'b0;
    run(25);
    chk("hold_still_wait", 32'(dut.state), 32'(WAIT_IN));
    btn_insert = 1'b1;
    wait_ins(40, got, n);
    chk("hold_insert_seen", {31'h0, got}, 32'h1);
    chk("hold_latency",     n, 32'd20);
    chk("hold_data",        in_data, 32'h0000_0077);
    is_in = 1'b0;
    run(2);
    btn_insert = 1'b0;
    run(25);
    chk("hold_ins_count", ins_cnt, 32'd4);
    chk("hold_we_count",  we_cnt, 32'd3);

    // Both IN and OUT from a fresh reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    chk("both_rst_out", out_data, 32'h0);
    is_in = 1'b1; is_out = 1'b1; out_src = 32'hCAFE_F00D; switches = 32'h0000_0011;
    #1;
    chk("both_flags", {30'h0, input_flag, output_flag}, 32'h2);
    tick();
    chk("both_state",     32'(dut.state), 32'(WAIT_IN));
    chk("both_out_data",  out_data, 32'h0);
    chk("both_out_valid", {31'h0, out_valid}, 32'h0);
    chk("both_oflag_low", {31'h0, output_flag}, 32'h0);
    btn_insert = 1'b1;
    wait_ins(40, got, n);
    chk("both_insert_seen", {31'h0, got}, 32'h1);
    chk("both_in_data",     in_data, 32'h0000_0011);
    is_in = 1'b0; is_out = 1'b0;
    run(2);
    btn_insert = 1'b0;
    run(25);
    chk("both_ins_count", ins_cnt, 32'd5);

    // Reset during WAIT_OUT
    is_out = 1'b1; out_src = 32'h0000_1234;
    tick();
    chk("rw_state", 32'(dut.state), 32'(WAIT_OUT));
    chk("rw_data",  out_data, 32'h0000_1234);
    is_out = 1'b0;
    run(3);
    ins_save = ins_cnt; we_save = we_cnt;
    reset = 1'b1;
    #1;
    chk("rw_abort_state", 32'(dut.state), 32'(IDLE));
    chk("rw_out_clr",     out_data, 32'h0);
    chk("rw_valid_clr",   {31'h0, out_valid}, 32'h0);
    tick();
    reset = 1'b0;
    run(5);
    chk("rw_no_insert", ins_cnt, ins_save);
    chk("rw_no_we",     we_cnt, we_save);
    chk("rw_idle",      32'(dut.state), 32'(IDLE));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/io_handshake.md
# io_handshake

I/O handshake controller for the multicycle-free MIPS core; this is the block that drives the PC's `input_flag`, `output_flag` and `insert` controls. When the decoder flags an IN or OUT instruction, the block holds the PC by raising the matching flag. It then waits for a debounced press of the board's insert button. On the press it either captures the switch word for the register file (IN) or acknowledges the displayed word (OUT), and pulses `insert` so the PC advances.

## Interface
- `DEBOUNCE_CYCLES`, 16, number of consecutive stable samples before a button level change is accepted (board build overrides, e.g. 500000).
- `DATA_W`, 32, width of the switch input and display output words.

- `CLK`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-high; clears every register.
- `is_in`  in  1  decoded current instruction is IN.
- `is_out`  in  1  decoded current instruction is OUT.
- `out_src`  in  DATA_W  register-file read value to display on OUT.
- `switches`  in  DATA_W  board switch word, quasi-static.
- `btn_insert`  in  1  raw, asynchronous, bouncing insert button (1 = pressed).
- `input_flag`  out  1  PC hold request for IN.
- `output_flag`  out  1  PC hold request for OUT.
- `insert`  out  1  one-cycle PC release pulse.
- `in_data`  out  DATA_W  captured switch word for register write-back.
- `in_we`  out  1  one-cycle write-enable for `in_data`.
- `out_data`  out  DATA_W  display register.
- `out_valid`  out  1  `out_data` holds a value from a completed or pending OUT.

## Operation
- States: IDLE, WAIT_IN, WAIT_OUT, ACK_IN, ACK_OUT, RELEASE.
- **IDLE**
  - `is_in` → WAIT_IN.
  - `is_out` (and not `is_in`) → WAIT_OUT; `out_data` ← `out_src` and `out_valid` ← 1 at the same edge.
  - Both asserted: IN wins, OUT ignored.
- **WAIT_IN / WAIT_OUT**: wait for `press` (a one-cycle debounced rising-edge pulse); on `press` → ACK_IN / ACK_OUT.
- **ACK_IN**
  - `in_data` ← `switches` sampled at the edge entering ACK_IN, held until the next IN.
  - `in_we` = 1, `insert` = 1; → RELEASE.
- **ACK_OUT**: `insert` = 1; → RELEASE.
- **RELEASE**: one cycle with all flags low and `is_in`/`is_out` ignored, so the old instruction cannot retrigger while the new PC propagates; → IDLE.
- **Flag decoding**
  - `input_flag` = (IDLE & `is_in`) | WAIT_IN | ACK_IN.
  - `output_flag` = (IDLE & `is_out` & !`is_in`) | WAIT_OUT | ACK_OUT.
  - The IDLE terms are combinational so the PC is held in the same cycle the instruction first appears.
  - `insert` and `in_we` are Moore outputs.
- **Button path**
  - Two-flop synchronizer, then a saturating stability counter of width $clog2(DEBOUNCE_CYCLES+1).
  - Accepted level changes only after DEBOUNCE_CYCLES equal samples; `press` = accepted 0→1 transition.
  - A press seen in IDLE or RELEASE is discarded, not queued. Holding the button across instructions yields no extra press.

## Timing
- **Reset values**: state IDLE; `in_data` 0, `out_data` 0, `out_valid` 0, `in_we` 0, `insert` 0. Synchronizer, debounced level and counter are 0. Flags follow the decode, so they are 0 unless `is_in`/`is_out` are high in IDLE.
- **Latency**: raw button high → `press` = 2 (sync) + DEBOUNCE_CYCLES + 1 cycles; `press` → `insert` = 1 cycle; `insert` → IDLE = 2 cycles.
- Reset mid-WAIT or mid-ACK aborts with no `insert`/`in_we` pulse; `out_data` is cleared.
- **Widths**: no arithmetic on data. `switches` is not synchronized; it is sampled only in the ACK_IN entry cycle.

## Structure
- Package `io_pkg`: state enum `io_state_t`, default constants `IO_DATA_W` = 32 and `IO_DEBOUNCE_DEFAULT` = 16.
- Sub-module `btn_debounce`: synchronizer, counter and edge detector; params DEBOUNCE_CYCLES; ports `CLK`, `reset`, `btn_raw`, `level`, `press`.
- Top: FSM, data registers, flag decode.

## Test plan
- Reset, then `is_in`=1 with `switches`=0x0000_00A5 and a clean press held 20 cycles → `input_flag` high from the first cycle. Exactly one `insert` and one `in_we` pulse; `in_data`=0x0000_00A5; state reaches IDLE 2 cycles after `insert`.
- `is_out`=1 with `out_src`=0xDEAD_BEEF → `output_flag` high immediately, `out_data`=0xDEAD_BEEF and `out_valid`=1 one cycle later. `insert` fires once after the press; `in_we` never asserts.
- Bouncing press (toggle every 3 cycles for 12 cycles, then stable high) with DEBOUNCE_CYCLES=16 → exactly one `press`/`insert`, no earlier than 19 cycles after the last toggle.
- `is_in` and `is_out` both 1 → only `input_flag` high; `out_data` unchanged at 0.
- Button held through the IN acknowledge into a following IN → second IN stays in WAIT_IN with no `insert` until the button is released (debounced) and pressed again.
- Assert `reset` for 1 cycle in WAIT_OUT after `out_data`=0x1234 → state IDLE, `out_data`=0, `out_valid`=0, no `insert` pulse.
